// File: rtl/optical_conv_sequencer.sv
// ============================================================================
// Module   : optical_conv_sequencer
// Purpose  : Runs one DAC -> optical core -> ADC conversion for each accepted
//            AXI-Stream sample. The DAC code comes from the low bits of
//            s_axis_tdata. After the optical path settles, the block pulses
//            the ADC trigger, waits for the ADC latency and then returns the
//            captured code on the master stream. Only one sample is in flight
//            at a time, and upstream is back-pressured until the result has
//            been handed off.
// Revision : 1.0 - initial release
//
// Ports
//   clk               in   1           system clock
//   rst_n             in   1           asynchronous reset, active low
//   s_axis_tdata      in   DATA_WIDTH  input sample (only [DAC_WIDTH-1:0] used)
//   s_axis_tvalid     in   1           input valid
//   s_axis_tready     out  1           high only while idle and out of reset
//   s_axis_tlast      in   1           end of frame, latched with the sample
//   m_axis_tdata      out  DATA_WIDTH  zero-extended ADC code
//   m_axis_tvalid     out  1           result valid
//   m_axis_tready     in   1           downstream ready
//   m_axis_tlast      out  1           tlast of the sample that produced result
//   dac_out_parallel  out  DAC_WIDTH   registered DAC code (holds last value)
//   dac_valid         out  1           one-cycle DAC load strobe
//   adc_in_parallel   in   ADC_WIDTH   ADC parallel data
//   adc_clk_trigger   out  1           ADC conversion trigger
//   busy              out  1           high whenever a conversion is running
//   sample_count      out  16          completed result handshakes (wrapping)
// ============================================================================
`default_nettype none

module optical_conv_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int DAC_WIDTH      = 12,
  parameter int ADC_WIDTH      = 12,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TRIG_CYCLES    = 2,
  parameter int ADC_LAT_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [DAC_WIDTH-1:0]  dac_out_parallel,
  output logic                  dac_valid,
  input  logic [ADC_WIDTH-1:0]  adc_in_parallel,
  output logic                  adc_clk_trigger,
  output logic                  busy,
  output logic [15:0]           sample_count
);

  // A single down-counter times every state. It must be wide enough for
  // the longest phase.
  localparam int MAX_A      = (SETTLE_CYCLES > TRIG_CYCLES) ? SETTLE_CYCLES : TRIG_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > ADC_LAT_CYCLES) ? MAX_A : ADC_LAT_CYCLES;
  localparam int CNT_WIDTH  = $clog2(MAX_CYCLES + 1);

  // Each timed state is entered with N-1 and exits on the edge where the
  // counter reads zero. That gives exactly N cycles in the state.
  localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TRIG_LOAD   = CNT_WIDTH'(TRIG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ADC_LOAD    = CNT_WIDTH'(ADC_LAT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    TRIG     = 3'd2,
    WAIT_ADC = 3'd3,
    OUT      = 3'd4
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   cnt_d;
  logic                   accept;
  logic                   capture;
  logic                   handshake;

  logic [DAC_WIDTH-1:0]   dac_q;
  logic                   dac_valid_q;
  logic                   tlast_q;
  logic [ADC_WIDTH-1:0]   adc_q;
  logic [15:0]            count_q;

  // Only the DAC field of the input word is consumed. The rest is folded
  // into this sink so that the unused upper bits are intentional.
  logic                   unused_tdata_bits;
  assign unused_tdata_bits = ^s_axis_tdata;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state, counter reload and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    accept          = 1'b0;
    capture         = 1'b0;
    handshake       = 1'b0;
    s_axis_tready   = 1'b0;
    adc_clk_trigger = 1'b0;
    m_axis_tvalid   = 1'b0;
    busy            = 1'b1;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        // The reset state is IDLE, so ready is also gated by rst_n. This
        // keeps ready low while reset is asserted and lets it rise as soon
        // as reset is released.
        s_axis_tready = rst_n;
        if (s_axis_tvalid && rst_n) begin
          accept  = 1'b1;
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end

      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = TRIG;
          cnt_d   = TRIG_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      TRIG: begin
        adc_clk_trigger = 1'b1;
        if (cnt_q == '0) begin
          state_d = WAIT_ADC;
          cnt_d   = ADC_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      WAIT_ADC: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = OUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      OUT: begin
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) begin
          handshake = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: sample latches, ADC capture and completion counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_q       <= '0;
      dac_valid_q <= 1'b0;
      tlast_q     <= 1'b0;
      adc_q       <= '0;
      count_q     <= '0;
    end else begin
      // The strobe lasts for the single cycle after acceptance. dac_q then
      // keeps the code so that the optical core stays biased between samples.
      dac_valid_q <= accept;
      if (accept) begin
        dac_q   <= s_axis_tdata[DAC_WIDTH-1:0];
        tlast_q <= s_axis_tlast;
      end
      if (capture) begin
        adc_q <= adc_in_parallel;
      end
      if (handshake) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign dac_out_parallel = dac_q;
  assign dac_valid        = dac_valid_q;
  assign m_axis_tdata     = DATA_WIDTH'(adc_q);
  assign m_axis_tlast     = tlast_q;
  assign sample_count     = count_q;

endmodule

`default_nettype wire
